// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared constants and types for the data-memory responder.
// Holds the MMIO window base, register offsets (word index dm_addr[7:2]) and
// the CON_STATUS layout (bit0 full, bit1 empty, bit2 overflow, [15:8] count).
package dm_responder_pkg;

    localparam logic [7:0] MMIO_BASE      = 8'hFF;

    localparam logic [5:0] OFS_CON_DATA   = 6'h00;
    localparam logic [5:0] OFS_CON_STATUS = 6'h01;
    localparam logic [5:0] OFS_CYCLE_LO   = 6'h02;
    localparam logic [5:0] OFS_CYCLE_HI   = 6'h03;

    localparam int unsigned CYCLE_W = 64;

    // CON_STATUS read word, MSB first.
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        overflow;
        logic        empty;
        logic        full;
    } con_status_t;

endpackage

// File: rtl/dm_responder_console_fifo.sv
// console_fifo: show-ahead byte FIFO for the console transmit stream.
// Ports: clk, rst (sync, active-high); push/push_data (write side);
// valid/data/ready (pop side, pop on valid && ready); full, empty, count,
// sticky overflow, and ovf_clr to clear it.
module console_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    output logic                     valid,
    output logic [7:0]               data,
    input  logic                     ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          accept;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign valid  = !empty;
    // Head reads 0 while empty so tx_data is clean after reset.
    assign data   = empty ? 8'h00 : store[rd_ptr];
    assign pop    = valid && ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign accept = push && (!full || pop);

    // Pointer, count and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    // Byte storage; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (accept) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: target side of the core's dm_* port. Word RAM with byte-lane
// writes plus an MMIO window at 0xFF00 (console FIFO, 64-bit cycle counter).
// Ports: clk, rst (sync, active-high); dm_addr, dm_w_en, dm_write_data from
// the core's MEM stage; dm_read_data (combinational); tx_valid/tx_data/tx_ready
// console byte stream.
// Build option: DM_CONSOLE_EN includes the console FIFO; without it the
// console registers read 0 and tx_valid/tx_data stay 0.
module dm_responder #(
    parameter int unsigned RAM_AW    = 14,
    parameter int unsigned CON_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dm_addr,
    input  logic [3:0]  dm_w_en,
    input  logic [31:0] dm_write_data,
    output logic [31:0] dm_read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    import dm_responder_pkg::*;

    localparam int unsigned CNT_W = $clog2(CON_DEPTH) + 1;

    logic [31:0]        mem [2**RAM_AW];
    logic [RAM_AW-1:0]  ram_idx;
    logic               is_mmio;
    logic [5:0]         reg_sel;
    logic               wr_any;
    logic               cycle_clr;
    logic [CYCLE_W-1:0] cycle;
    con_status_t        status;
    logic               unused_bits;

    assign is_mmio   = (dm_addr[15:8] == MMIO_BASE);
    assign reg_sel   = dm_addr[7:2];
    assign ram_idx   = dm_addr[RAM_AW+1:2];
    assign wr_any    = |dm_w_en;
    assign cycle_clr = is_mmio && (reg_sel == OFS_CYCLE_LO) && wr_any;

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (!is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (dm_w_en[i]) mem[ram_idx][8*i +: 8] <= dm_write_data[8*i +: 8];
            end
        end
    end

    // Free-running cycle counter; a clear write beats the increment.
    always_ff @(posedge clk) begin
        if (rst || cycle_clr) cycle <= '0;
        else                  cycle <= cycle + 64'd1;
    end

`ifdef DM_CONSOLE_EN
    logic             con_push;
    logic             con_ovf_clr;
    logic             con_full;
    logic             con_empty;
    logic             con_ovf;
    logic [CNT_W-1:0] con_count;

    assign con_push    = is_mmio && (reg_sel == OFS_CON_DATA) && dm_w_en[0];
    assign con_ovf_clr = is_mmio && (reg_sel == OFS_CON_STATUS) && wr_any;

    console_fifo #(
        .DEPTH(CON_DEPTH)
    ) u_console (
        .clk       (clk),
        .rst       (rst),
        .push      (con_push),
        .push_data (dm_write_data[7:0]),
        .valid     (tx_valid),
        .data      (tx_data),
        .ready     (tx_ready),
        .full      (con_full),
        .empty     (con_empty),
        .count     (con_count),
        .overflow  (con_ovf),
        .ovf_clr   (con_ovf_clr)
    );

    // Status packs the FIFO state as seen at the start of the cycle.
    always_comb begin
        status          = '0;
        status.full     = con_full;
        status.empty    = con_empty;
        status.overflow = con_ovf;
        status.count    = 8'(con_count);
    end

    assign unused_bits = ^dm_addr[1:0];
`else
    assign tx_valid    = 1'b0;
    assign tx_data     = 8'h00;
    assign status      = '0;
    assign unused_bits = ^{dm_addr[1:0], tx_ready};
`endif

    // Read mux: RAM outside the window, register select inside it.
    always_comb begin
        dm_read_data = '0;
        if (!is_mmio) begin
            dm_read_data = mem[ram_idx];
        end else begin
            case (reg_sel)
                OFS_CON_STATUS: dm_read_data = status;
                OFS_CYCLE_LO:   dm_read_data = cycle[31:0];
                OFS_CYCLE_HI:   dm_read_data = cycle[63:32];
                default:        dm_read_data = '0;
            endcase
        end
    end

endmodule
